// File: rtl/alu_share_arb_pkg.sv
// Shared operand-side types for the ALU sharing arbiter: the datapath word and
// the in-flight ownership entry carried alongside each issued operation.
package Pu_types;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] Word;

    typedef struct packed {
        logic valid;
        logic slot;
    } Alu_owner;

endpackage

// File: rtl/alu_share_arb_owner_pipe.sv
// Fixed-depth shift register of ownership entries that tracks which slot owns
// each operation in flight through the ALU; frozen when en is low.
module alu_owner_pipe
    import Pu_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     resetb,
    input  logic     en,
    input  Alu_owner head,
    output Alu_owner tail
);

    Alu_owner stage [DEPTH];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= head;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tail = stage[DEPTH-1];

endmodule

// File: rtl/alu_share_arb.sv
// Two-slot arbiter and issue register sharing one fixed-latency ALU, with
// result routing back to the issuing slot. Optional grant lock: ALU_ARB_LOCK_EN.
module alu_share_arb
    import Pu_types::*;
#(
    parameter int LATENCY    = 2,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  Word        req_a [2],
    input  Word        req_b [2],
    input  logic [1:0] req_cin,
    input  Word        req_cr [2],
    input  logic [1:0] req_lock,
    output logic       alu_valid,
    output Word        alu_a,
    output Word        alu_b,
    output Word        alu_cr,
    output logic       alu_cin,
    input  logic       alu_stall,
    input  Word        alu_res,
    input  logic       alu_res_valid,
    output logic [1:0] res_valid,
    output Word        res_data,
    output logic       err
);

    logic       last_grant;
    logic       issue_slot;
    logic [1:0] grant;
    logic       xfer;
    logic       sel;
    Alu_owner   head;
    Alu_owner   tail;

`ifdef ALU_ARB_LOCK_EN
    logic lock_active;
    logic lock_owner;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Handshake: a slot transfers in any cycle where req_valid[s] & req_ready[s];
    // req_ready never depends on the operand values and is zero while stalled.
    always_comb begin
        grant = 2'b00;
        if (req_valid == 2'b11) begin
            grant = (FIXED_PRIO || last_grant) ? 2'b01 : 2'b10;
        end else begin
            grant = req_valid;
        end
`ifdef ALU_ARB_LOCK_EN
        if (lock_active) grant = req_valid & (lock_owner ? 2'b10 : 2'b01);
`endif
        if (alu_stall) grant = 2'b00;
    end

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);
    assign sel       = grant[1];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            alu_valid  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cr     <= '0;
            alu_cin    <= 1'b0;
            issue_slot <= 1'b0;
            last_grant <= 1'b1;
        end else if (!alu_stall) begin
            alu_valid <= xfer;
            if (xfer) begin
                alu_a      <= req_a[sel];
                alu_b      <= req_b[sel];
                alu_cr     <= req_cr[sel];
                alu_cin    <= req_cin[sel];
                issue_slot <= sel;
                last_grant <= sel;
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // The owner's own transfer decides whether the lock persists; idling keeps it.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
        end else if (xfer) begin
            lock_active <= req_lock[sel];
            lock_owner  <= sel;
        end
    end
`endif

    // Entries enter as the issue register is consumed, so the tail lines up
    // with alu_res_valid exactly LATENCY unstalled cycles after issue.
    assign head = '{valid: alu_valid, slot: issue_slot};

    alu_owner_pipe #(
        .DEPTH (LATENCY)
    ) u_owner_pipe (
        .clk    (clk),
        .resetb (resetb),
        .en     (!alu_stall),
        .head   (head),
        .tail   (tail)
    );

    always_comb begin
        res_valid = 2'b00;
        if (alu_res_valid && tail.valid && !alu_stall) res_valid[tail.slot] = 1'b1;
    end

    assign res_data = alu_res;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            err <= 1'b0;
        end else if (alu_res_valid && !tail.valid && !alu_stall) begin
            err <= 1'b1;
        end
    end

endmodule
